mcpu_ctrl_fsm: RTL and testbench
================================

# mcpu_ctrl_fsm

Parametrised multi-cycle control unit for the 32-bit MIPS-subset multi-cycle CPU. It sequences fetch, decode, execute, memory and writeback, and drives every register enable, write enable and mux select in the datapath. Memory accesses use a variable-latency request/acknowledge handshake with a bounded timeout. Illegal instructions and memory timeouts go to a sticky trap state.

## Interface
- ACK_TIMEOUT, 16, max cycles a memory request waits for `mem_ack`; 0 = no timeout
- ALU_OP_W, 3, width of `alu_op`

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag (combinational, current cycle)
- mem_ack  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request
- mem_we  out  1  memory write (valid only with mem_req)
- iord  out  1  address select: 0 PC, 1 ALU result register
- pc_we, ir_we, a_we, b_we, ben_we, reg_we  out  1 each  register/regfile enables
- alusrca  out  2  0 PC, 1 A, 2 BEN, 3 zero
- alusrcb  out  2  0 imm<<2, 1 sign-ext imm, 2 B, 3 const 4
- alu_op  out  ALU_OP_W  0 ADD, 1 SUB, 2 XOR, 3 SLT
- reg_dst  out  2  0 rd, 1 rt, 2 r31
- mem_to_reg  out  2  0 MDR, 1 ALU register, 2 PC
- pc_src  out  2  0 BEN, 1 {PC[31:28],jaddr,2'b00}, 2 ALU out, 3 A
- illegal, mem_err  out  1 each  sticky trap causes

## Operation
- States: FETCH, DECODE, R_EXEC, R_WB, I_EXEC, I_WB, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, BRANCH, JUMP, JAL, JR, TRAP.
- Default output value is 0 for every output. Each state lists only the outputs it asserts.
- FETCH: mem_req, iord=0. When `mem_ack` is high, also assert ir_we and pc_we with alusrca=0, alusrcb=3, ADD, pc_src=2, then go to DECODE. Otherwise stay in FETCH.
- DECODE: a_we, b_we, ben_we. The ALU computes PC + (imm<<2) (alusrca=0, alusrcb=0, ADD). Dispatch on opcode:
  - 0x00: funct 0x20/0x22/0x2a/0x26 → R_EXEC; funct 0x08 → JR
  - 0x08/0x0e → I_EXEC
  - 0x23/0x2b → MEM_ADDR
  - 0x04/0x05 → BRANCH
  - 0x02 → JUMP
  - 0x03 → JAL
  - anything else → TRAP with illegal=1
- R_EXEC: alusrca=1, alusrcb=2, alu_op from funct (ADD/SUB/SLT/XOR). Next R_WB: reg_we, reg_dst=0, mem_to_reg=1.
- I_EXEC: alusrca=1, alusrcb=1, ADD (0x08) or XOR (0x0e). Next I_WB: reg_we, reg_dst=1, mem_to_reg=1.
- MEM_ADDR: alusrca=1, alusrcb=1, ADD. Next MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: mem_req, iord=1; on ack go to MEM_WB.
- MEM_WB: reg_we, reg_dst=1, mem_to_reg=0.
- MEM_WR: mem_req, mem_we, iord=1; on ack go to FETCH.
- BRANCH: alusrca=1, alusrcb=2, SUB, pc_src=0. pc_we = zero XOR (opcode==0x05).
- JUMP: pc_we, pc_src=1.
- JAL: pc_we, pc_src=1, reg_we, reg_dst=2, mem_to_reg=2. The PC already holds PC+4, and the regfile captures it on the same edge the PC updates.
- JR: pc_we, pc_src=3.
- R_WB, I_WB, MEM_WB, BRANCH, JUMP, JAL and JR all go to FETCH next.
- TRAP: all enables 0. The state is left only by reset. illegal/mem_err hold their values.
- Timeout: the wait counter clears on entry to FETCH/MEM_RD/MEM_WR and increments each cycle without ack. If no ack has arrived in ACK_TIMEOUT cycles, go to TRAP with mem_err=1. An ack in cycle ACK_TIMEOUT itself is accepted.

## Timing
- Outputs are combinational from state. mem_ack gates ir_we/pc_we in FETCH and the exits from the wait states.
- While `reset` is high, all outputs are 0. The state register, counter, illegal and mem_err reset to FETCH/0/0/0. The first cycle after reset deasserts is FETCH with mem_req=1.
- Reset mid-instruction or in TRAP aborts unconditionally. No partial write is emitted during a reset cycle.
- Cycle counts with zero-wait memory: R/I-type 4, lw 5, sw 4, branch/jump/jr/jal 3. Each memory wait cycle adds 1.
- mem_req stays high and iord/mem_we stay stable until the ack cycle.

## Configuration
- MCPU_JAL_EN:
  - Defined: JAL (0x03) and JR (funct 0x08) are decoded as above.
  - Undefined: the JAL/JR states are not compiled, both encodings go to TRAP with illegal=1, and reg_dst/mem_to_reg never take value 2.

## Structure
- Shared package `mcpu_pkg`: state enum, opcode/funct constants, alusrca/alusrcb/pc_src/reg_dst/mem_to_reg encodings, ALU op constants.
- Sub-module `mcpu_ctrl_decode`: combinational opcode/funct → next-state class, alu_op for R_EXEC/I_EXEC, illegal.

## Test plan
- Reset, then mem_ack=1 in the first FETCH cycle → mem_req=1, iord=0, ir_we=1, pc_we=1, alusrcb=3, pc_src=2 in that cycle; DECODE next.
- add (opcode 0, funct 0x20) with zero-wait memory → FETCH, DECODE, R_EXEC, R_WB. reg_we=1 only in R_WB with reg_dst=0, mem_to_reg=1; alu_op=0 in R_EXEC.
- lw with mem_ack delayed 3 cycles in both FETCH and MEM_RD → 11 total cycles. iord=1 throughout MEM_RD; reg_we in MEM_WB with mem_to_reg=0.
- beq with zero=1 → pc_we=1, pc_src=0 in BRANCH. bne with zero=1 → pc_we=0. FETCH next in both cases.
- ACK_TIMEOUT=4, mem_ack held 0 → TRAP after 4 FETCH cycles with mem_err=1. Later acks are ignored, and reset returns to FETCH with mem_err=0.
- opcode 0x03: with MCPU_JAL_EN → JAL state with reg_dst=2, pc_src=1. Without it → TRAP with illegal=1. opcode 0x3f → illegal=1 in both builds.

Source files
------------

// File: rtl/mcpu_pkg.sv
// Shared types and encodings for the multi-cycle MIPS-subset control unit.
// JAL/JR states exist only when MCPU_JAL_EN is defined.
package mcpu_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, R_EXEC, R_WB, I_EXEC, I_WB,
    MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, BRANCH, JUMP,
`ifdef MCPU_JAL_EN
    JAL, JR,
`endif
    TRAP
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_XORI  = 6'h0e;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_SLT = 6'h2a;

  localparam logic [1:0] ASA_PC   = 2'd0;
  localparam logic [1:0] ASA_A    = 2'd1;
  localparam logic [1:0] ASB_IMM2 = 2'd0;
  localparam logic [1:0] ASB_IMM  = 2'd1;
  localparam logic [1:0] ASB_B    = 2'd2;
  localparam logic [1:0] ASB_FOUR = 2'd3;

  localparam logic [1:0] PC_BEN = 2'd0;
  localparam logic [1:0] PC_JMP = 2'd1;
  localparam logic [1:0] PC_ALU = 2'd2;
  localparam logic [1:0] PC_A   = 2'd3;

  localparam logic [1:0] RD_RD  = 2'd0;
  localparam logic [1:0] RD_RT  = 2'd1;
  localparam logic [1:0] RD_R31 = 2'd2;

  localparam logic [1:0] M2R_MDR = 2'd0;
  localparam logic [1:0] M2R_ALU = 2'd1;
  localparam logic [1:0] M2R_PC  = 2'd2;

  localparam int ALU_ADD = 0;
  localparam int ALU_SUB = 1;
  localparam int ALU_XOR = 2;
  localparam int ALU_SLT = 3;

endpackage

// File: rtl/mcpu_ctrl_decode.sv
// Opcode/funct decode: DECODE successor state and exec-stage ALU op.
// JAL/JR decode only when MCPU_JAL_EN is defined.
module mcpu_ctrl_decode
  import mcpu_pkg::*;
#(
  parameter int ALU_OP_W = 3
) (
  input  logic [5:0]          opcode,
  input  logic [5:0]          funct,
  output state_t              nxt,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                illegal
);

  always_comb begin
    nxt    = TRAP;
    alu_op = ALU_OP_W'(ALU_ADD);
    case (opcode)
      OP_RTYPE: begin
        if (funct inside {FN_ADD, FN_SUB, FN_SLT, FN_XOR})
          nxt = R_EXEC;
`ifdef MCPU_JAL_EN
        else if (funct == FN_JR)
          nxt = JR;
`endif
        unique case (1'b1)
          funct == FN_SUB: alu_op = ALU_OP_W'(ALU_SUB);
          funct == FN_XOR: alu_op = ALU_OP_W'(ALU_XOR);
          funct == FN_SLT: alu_op = ALU_OP_W'(ALU_SLT);
          default:         alu_op = ALU_OP_W'(ALU_ADD);
        endcase
      end
      OP_ADDI: nxt = I_EXEC;
      OP_XORI: begin
        nxt    = I_EXEC;
        alu_op = ALU_OP_W'(ALU_XOR);
      end
      OP_LW, OP_SW:   nxt = MEM_ADDR;
      OP_BEQ, OP_BNE: nxt = BRANCH;
      OP_J:           nxt = JUMP;
`ifdef MCPU_JAL_EN
      OP_JAL:         nxt = JAL;
`endif
      default:        nxt = TRAP;
    endcase
  end

  assign illegal = (nxt == TRAP);

endmodule

// File: rtl/mcpu_ctrl_fsm.sv
// Multi-cycle control FSM with ack-timeout and sticky trap causes.
// Optional MCPU_JAL_EN enables the JAL and JR paths.
module mcpu_ctrl_fsm
  import mcpu_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16,
  parameter int ALU_OP_W    = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [5:0]          opcode,
  input  logic [5:0]          funct,
  input  logic                zero,
  input  logic                mem_ack,
  output logic                mem_req,
  output logic                mem_we,
  output logic                iord,
  output logic                pc_we,
  output logic                ir_we,
  output logic                a_we,
  output logic                b_we,
  output logic                ben_we,
  output logic                reg_we,
  output logic [1:0]          alusrca,
  output logic [1:0]          alusrcb,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic [1:0]          reg_dst,
  output logic [1:0]          mem_to_reg,
  output logic [1:0]          pc_src,
  output logic                illegal,
  output logic                mem_err
);

  localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CW-1:0] CMAX =
    (ACK_TIMEOUT > 0) ? CW'(ACK_TIMEOUT - 1) : '0;

  state_t              state;
  state_t              dec_nxt;
  logic [ALU_OP_W-1:0] dec_aop;
  logic                dec_ill;
  logic [CW-1:0]       cnt;
  logic                ill_q;
  logic                merr_q;
  logic                waiting;
  logic                tmo;

  mcpu_ctrl_decode #(.ALU_OP_W(ALU_OP_W)) u_dec (
    .opcode  (opcode),
    .funct   (funct),
    .nxt     (dec_nxt),
    .alu_op  (dec_aop),
    .illegal (dec_ill)
  );

  assign waiting = state inside {FETCH, MEM_RD, MEM_WR};
  assign tmo     = (ACK_TIMEOUT != 0) && (cnt == CMAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= FETCH;
      cnt    <= '0;
      ill_q  <= 1'b0;
      merr_q <= 1'b0;
    end else begin
      cnt <= '0;
      if (waiting && !mem_ack) begin
        if (tmo) begin
          state  <= TRAP;
          merr_q <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        unique case (state)
          FETCH:    state <= DECODE;
          DECODE: begin
            state <= dec_nxt;
            if (dec_ill) ill_q <= 1'b1;
          end
          R_EXEC:   state <= R_WB;
          I_EXEC:   state <= I_WB;
          MEM_ADDR: state <= (opcode == OP_LW) ? MEM_RD : MEM_WR;
          MEM_RD:   state <= MEM_WB;
          TRAP:     state <= TRAP;
          default:  state <= FETCH;
        endcase
      end
    end
  end

  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    pc_we      = 1'b0;
    ir_we      = 1'b0;
    a_we       = 1'b0;
    b_we       = 1'b0;
    ben_we     = 1'b0;
    reg_we     = 1'b0;
    alusrca    = ASA_PC;
    alusrcb    = ASB_IMM2;
    alu_op     = ALU_OP_W'(ALU_ADD);
    reg_dst    = RD_RD;
    mem_to_reg = M2R_MDR;
    pc_src     = PC_BEN;
    illegal    = 1'b0;
    mem_err    = 1'b0;
    if (!reset) begin
      illegal = ill_q;
      mem_err = merr_q;
      unique case (state)
        FETCH: begin
          mem_req = 1'b1;
          if (mem_ack) begin
            ir_we   = 1'b1;
            pc_we   = 1'b1;
            alusrcb = ASB_FOUR;
            pc_src  = PC_ALU;
          end
        end
        DECODE: begin
          a_we   = 1'b1;
          b_we   = 1'b1;
          ben_we = 1'b1;
        end
        R_EXEC: begin
          alusrca = ASA_A;
          alusrcb = ASB_B;
          alu_op  = dec_aop;
        end
        I_EXEC: begin
          alusrca = ASA_A;
          alusrcb = ASB_IMM;
          alu_op  = dec_aop;
        end
        R_WB, I_WB: begin
          reg_we     = 1'b1;
          reg_dst    = (state == R_WB) ? RD_RD : RD_RT;
          mem_to_reg = M2R_ALU;
        end
        MEM_ADDR: begin
          alusrca = ASA_A;
          alusrcb = ASB_IMM;
        end
        MEM_RD: begin
          mem_req = 1'b1;
          iord    = 1'b1;
        end
        MEM_WB: begin
          reg_we     = 1'b1;
          reg_dst    = RD_RT;
          mem_to_reg = M2R_MDR;
        end
        MEM_WR: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          iord    = 1'b1;
        end
        BRANCH: begin
          alusrca = ASA_A;
          alusrcb = ASB_B;
          alu_op  = ALU_OP_W'(ALU_SUB);
          pc_src  = PC_BEN;
          pc_we   = zero ^ (opcode == OP_BNE);
        end
        JUMP: begin
          pc_we  = 1'b1;
          pc_src = PC_JMP;
        end
`ifdef MCPU_JAL_EN
        JAL: begin
          pc_we      = 1'b1;
          pc_src     = PC_JMP;
          reg_we     = 1'b1;
          reg_dst    = RD_R31;
          mem_to_reg = M2R_PC;
        end
        JR: begin
          pc_we  = 1'b1;
          pc_src = PC_A;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mcpu_ctrl_fsm.sv
// Randomized bench for mcpu_ctrl_fsm against an instruction-level model.
// Honors MCPU_JAL_EN the same way as the design.
module tb_mcpu_ctrl_fsm;

  localparam int TMO = 4;
`ifdef MCPU_JAL_EN
  localparam bit JAL_EN = 1'b1;
`else
  localparam bit JAL_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic       zero = 1'b0;
  logic       mem_ack = 1'b0;
  logic       mem_req, mem_we, iord, pc_we, ir_we;
  logic       a_we, b_we, ben_we, reg_we;
  logic [1:0] alusrca, alusrcb, reg_dst, mem_to_reg, pc_src;
  logic [2:0] alu_op;
  logic       illegal, mem_err;

  always #5 clk = ~clk;

  mcpu_ctrl_fsm #(.ACK_TIMEOUT(TMO), .ALU_OP_W(3)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
    .zero(zero), .mem_ack(mem_ack), .mem_req(mem_req),
    .mem_we(mem_we), .iord(iord), .pc_we(pc_we), .ir_we(ir_we),
    .a_we(a_we), .b_we(b_we), .ben_we(ben_we), .reg_we(reg_we),
    .alusrca(alusrca), .alusrcb(alusrcb), .alu_op(alu_op),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .pc_src(pc_src),
    .illegal(illegal), .mem_err(mem_err)
  );

  typedef struct packed {
    logic mem_req, mem_we, iord, pc_we, ir_we;
    logic a_we, b_we, ben_we, reg_we;
    logic [1:0] asa, asb;
    logic [2:0] aop;
    logic [1:0] rdst, m2r, psrc;
    logic ill, merr;
  } ov_t;

  typedef struct {
    logic       ack;
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    ov_t        e;
    string      tag;
  } step_t;

  ov_t act;
  assign act = {mem_req, mem_we, iord, pc_we, ir_we, a_we, b_we,
                ben_we, reg_we, alusrca, alusrcb, alu_op, reg_dst,
                mem_to_reg, pc_src, illegal, mem_err};

  step_t      q[$];
  int         checks = 0;
  int         errors = 0;
  bit         trapped;
  logic [5:0] cur_op, cur_fn;
  logic       cur_z;

  task automatic chk(string tag, ov_t got, ov_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(logic a, ov_t e, string t);
    q.push_back('{a, cur_op, cur_fn, cur_z, e,
                  $sformatf("%s op%h fn%h", t, cur_op, cur_fn)});
  endtask

  task automatic trap(logic il, logic me);
    ov_t e;
    e = '0;
    e.ill = il;
    e.merr = me;
    repeat (3) push(1'($urandom_range(1)), e, "trap");
    trapped = 1'b1;
  endtask

  // d wait cycles then an ack; d >= TMO means the ack never comes
  task automatic mem_phase(int d, ov_t w, ov_t k, string t);
    for (int i = 0; i < d && i < TMO; i++) push(1'b0, w, {t, "_wait"});
    if (d >= TMO) trap(1'b0, 1'b1);
    else push(1'b1, k, {t, "_ack"});
  endtask

  task automatic gen(logic [5:0] op, logic [5:0] fn, logic z,
                     int df, int dm);
    ov_t e, k;
    bit  r_ok;
    cur_op = op;
    cur_fn = fn;
    cur_z = z;
    trapped = 1'b0;
    e = '0;
    e.mem_req = 1'b1;
    k = e;
    k.ir_we = 1'b1;
    k.pc_we = 1'b1;
    k.asb = 2'd3;
    k.psrc = 2'd2;
    mem_phase(df, e, k, "fetch");
    if (trapped) return;
    e = '0;
    e.a_we = 1'b1;
    e.b_we = 1'b1;
    e.ben_we = 1'b1;
    push(1'b0, e, "decode");
    r_ok = (fn == 6'h20) || (fn == 6'h22) || (fn == 6'h2a) || (fn == 6'h26);
    e = '0;
    if (op == 6'h00 && r_ok) begin
      e.asa = 2'd1;
      e.asb = 2'd2;
      e.aop = (fn == 6'h22) ? 3'd1 : (fn == 6'h26) ? 3'd2 :
              (fn == 6'h2a) ? 3'd3 : 3'd0;
      push(1'b0, e, "r_exec");
      e = '0;
      e.reg_we = 1'b1;
      e.m2r = 2'd1;
      push(1'b0, e, "r_wb");
    end else if (op == 6'h08 || op == 6'h0e) begin
      e.asa = 2'd1;
      e.asb = 2'd1;
      e.aop = (op == 6'h0e) ? 3'd2 : 3'd0;
      push(1'b0, e, "i_exec");
      e = '0;
      e.reg_we = 1'b1;
      e.rdst = 2'd1;
      e.m2r = 2'd1;
      push(1'b0, e, "i_wb");
    end else if (op == 6'h23 || op == 6'h2b) begin
      e.asa = 2'd1;
      e.asb = 2'd1;
      push(1'b0, e, "mem_addr");
      e = '0;
      e.mem_req = 1'b1;
      e.iord = 1'b1;
      e.mem_we = (op == 6'h2b);
      mem_phase(dm, e, e, (op == 6'h2b) ? "mem_wr" : "mem_rd");
      if (!trapped && op == 6'h23) begin
        e = '0;
        e.reg_we = 1'b1;
        e.rdst = 2'd1;
        push(1'b0, e, "mem_wb");
      end
    end else if (op == 6'h04 || op == 6'h05) begin
      e.asa = 2'd1;
      e.asb = 2'd2;
      e.aop = 3'd1;
      e.pc_we = (op == 6'h04) ? z : !z;
      push(1'b0, e, "branch");
    end else if (op == 6'h02) begin
      e.pc_we = 1'b1;
      e.psrc = 2'd1;
      push(1'b0, e, "jump");
    end else if (JAL_EN && op == 6'h03) begin
      e.pc_we = 1'b1;
      e.psrc = 2'd1;
      e.reg_we = 1'b1;
      e.rdst = 2'd2;
      e.m2r = 2'd2;
      push(1'b0, e, "jal");
    end else if (JAL_EN && op == 6'h00 && fn == 6'h08) begin
      e.pc_we = 1'b1;
      e.psrc = 2'd3;
      push(1'b0, e, "jr");
    end else begin
      trap(1'b1, 1'b0);
    end
  endtask

  task automatic run_n(int n);
    step_t s;
    for (int i = 0; i < n && q.size() > 0; i++) begin
      s = q.pop_front();
      @(negedge clk);
      opcode = s.op;
      funct = s.fn;
      zero = s.z;
      mem_ack = s.ack;
      #1 chk(s.tag, act, s.e);
    end
    q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    mem_ack = 1'($urandom_range(1));
    opcode = 6'($urandom);
    #1 chk("reset", act, '0);
    @(posedge clk);
    #1 reset = 1'b0;
    mem_ack = 1'b0;
  endtask

  task automatic one(logic [5:0] op, logic [5:0] fn, logic z,
                     int df, int dm);
    gen(op, fn, z, df, dm);
    run_n(q.size());
    if (trapped) do_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  logic [5:0] ops[10];
  logic [5:0] fns[6];

  initial begin
    ops = '{6'h00, 6'h08, 6'h0e, 6'h23, 6'h2b,
            6'h04, 6'h05, 6'h02, 6'h03, 6'h3f};
    fns = '{6'h20, 6'h22, 6'h2a, 6'h26, 6'h08, 6'h01};
    do_reset();
    one(6'h00, 6'h20, 1'b0, 0, 0);
    one(6'h23, 6'h00, 1'b0, 3, 3);
    one(6'h04, 6'h00, 1'b1, 0, 0);
    one(6'h05, 6'h00, 1'b1, 0, 0);
    one(6'h2b, 6'h00, 1'b0, 1, 3);
    one(6'h00, 6'h00, 1'b0, TMO, 0);
    one(6'h00, 6'h22, 1'b0, 0, 0);
    one(6'h03, 6'h00, 1'b0, 0, 0);
    one(6'h3f, 6'h00, 1'b0, 0, 0);
    one(6'h00, 6'h08, 1'b0, 0, 0);
    one(6'h23, 6'h00, 1'b0, 0, TMO);
    for (int it = 0; it < 400; it++) begin
      logic [5:0] op, fn;
      int         df, dm;
      op = ops[$urandom_range(9)];
      if ($urandom_range(9) == 0) op = 6'($urandom);
      fn = fns[$urandom_range(5)];
      df = ($urandom_range(24) == 0) ? TMO : $urandom_range(3);
      dm = ($urandom_range(24) == 0) ? TMO : $urandom_range(3);
      gen(op, fn, 1'($urandom_range(1)), df, dm);
      if ($urandom_range(14) == 0) begin
        run_n($urandom_range(q.size()));
        do_reset();
      end else begin
        run_n(q.size());
        if (trapped) do_reset();
      end
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
